// File: rtl/viewport_ctrl.sv
// Viewport controller: registered colour path, prescaled start-up sequencer and button-driven origin pan.
// Build option VIEWPORT_WRAP_EN: origin coordinates wrap modulo (MAX+1) instead of clamping.
module viewport_ctrl #(
  parameter int unsigned CDEPTH       = 1,
  parameter int unsigned ORG_W        = 10,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MAX        = 479,
  parameter int unsigned X_INIT       = 300,
  parameter int unsigned Y_INIT       = 200,
  parameter int unsigned STEP         = 2,
  parameter int unsigned ACCEL_FRAMES = 16,
  parameter int unsigned DIV          = 4096,
  parameter int unsigned DISP_DELAY   = 6,
  parameter int unsigned CALC_DELAY   = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  vnotactive,
  input  logic                  up,
  input  logic                  down,
  input  logic                  left,
  input  logic                  right,
  input  logic [3*CDEPTH-1:0]   pix_in,
  output logic [CDEPTH-1:0]     red,
  output logic [CDEPTH-1:0]     green,
  output logic [CDEPTH-1:0]     blue,
  output logic [ORG_W-1:0]      originX,
  output logic [ORG_W-1:0]      originY,
  output logic                  disp_enable,
  output logic                  calc_enable,
  output logic                  tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = $clog2(CALC_DELAY + 1);
  localparam int unsigned HW = $clog2(ACCEL_FRAMES + 1);
  localparam int unsigned AW = ORG_W + 1;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_ARM  = 2'd1,
    ST_DONE = 2'd2
  } pan_state_t;

  pan_state_t    state;
  logic [PW-1:0] pre_cnt;
  logic [SW-1:0] su_cnt;
  logic [HW-1:0] hold_cnt;
  logic          any_btn;
  logic [AW-1:0] pan_step;
  logic [AW-1:0] x_next;
  logic [AW-1:0] y_next;

  // One bounded move of o by s; the extra bit keeps o+s free of overflow.
  function automatic logic [AW-1:0] pan_move(input logic [AW-1:0] o,
                                             input logic [AW-1:0] s,
                                             input logic [AW-1:0] mx,
                                             input logic          dec);
    logic [AW-1:0] sum;
    sum = o + s;
    if (dec) begin
`ifdef VIEWPORT_WRAP_EN
      pan_move = (o < s) ? (mx + AW'(1) - (s - o)) : (o - s);
`else
      pan_move = (o < s) ? '0 : (o - s);
`endif
    end else begin
`ifdef VIEWPORT_WRAP_EN
      pan_move = (sum > mx) ? (sum - (mx + AW'(1))) : sum;
`else
      pan_move = (sum > mx) ? mx : sum;
`endif
    end
  endfunction

  // Candidate origins for this cycle; up/left win over down/right.
  always_comb begin
    any_btn  = ~(up & down & left & right);
    pan_step = (hold_cnt < HW'(ACCEL_FRAMES)) ? AW'(STEP) : AW'(STEP * 4);
    x_next   = AW'(originX);
    y_next   = AW'(originY);
    if (!left)       x_next = pan_move(AW'(originX), pan_step, AW'(X_MAX), 1'b1);
    else if (!right) x_next = pan_move(AW'(originX), pan_step, AW'(X_MAX), 1'b0);
    if (!up)         y_next = pan_move(AW'(originY), pan_step, AW'(Y_MAX), 1'b1);
    else if (!down)  y_next = pan_move(AW'(originY), pan_step, AW'(Y_MAX), 1'b0);
  end

  // Prescaler and start-up sequencer; enables latch on the tick that leaves each delay value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre_cnt     <= '0;
      tick        <= 1'b0;
      su_cnt      <= '0;
      disp_enable <= 1'b0;
      calc_enable <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == PW'(DIV - 1)) ? '0 : pre_cnt + PW'(1);
      tick    <= (pre_cnt == PW'(DIV - 2));
      if (tick) begin
        if (su_cnt != SW'(CALC_DELAY)) su_cnt <= su_cnt + SW'(1);
        if (su_cnt == SW'(DISP_DELAY)) disp_enable <= 1'b1;
        if (su_cnt == SW'(CALC_DELAY)) calc_enable <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      {red, green, blue} <= '1;
    end else if (disp_enable) begin
      {red, green, blue} <= pix_in;
    end
  end

  // Pan FSM: a single ARM cycle per blanking interval commits at most one move.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_WAIT;
      hold_cnt <= '0;
      originX  <= ORG_W'(X_INIT);
      originY  <= ORG_W'(Y_INIT);
    end else begin
      case (state)
        ST_WAIT: if (vnotactive) state <= ST_ARM;
        ST_ARM: begin
          originX <= ORG_W'(x_next);
          originY <= ORG_W'(y_next);
          if (any_btn) begin
            state <= ST_DONE;
            if (hold_cnt != HW'(ACCEL_FRAMES)) hold_cnt <= hold_cnt + HW'(1);
          end else begin
            hold_cnt <= '0;
            if (!vnotactive) state <= ST_WAIT;
          end
        end
        ST_DONE: if (!vnotactive) state <= ST_WAIT;
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_viewport_ctrl.sv
// Self-checking bench for viewport_ctrl: start-up timing, colour latency, panning, acceleration, bounds, reset.
module tb_viewport_ctrl;

  localparam int unsigned CDEPTH     = 1;
  localparam int unsigned PIXW       = 3 * CDEPTH;
  localparam int unsigned ORG_W      = 10;
  localparam int          X_MAX      = 639;
  localparam int          Y_MAX      = 479;
  localparam int          X_INIT     = 300;
  localparam int          Y_INIT     = 200;
  localparam int          STEP       = 2;
  localparam int          ACCEL      = 16;
  localparam int          DIV        = 4;
  localparam int          DISP_DELAY = 6;
  localparam int          CALC_DELAY = 15;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              vnotactive = 1'b0;
  logic              up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
  logic [PIXW-1:0]   pix_in = '0;
  logic [CDEPTH-1:0] red, green, blue;
  logic [ORG_W-1:0]  originX, originY;
  logic              disp_enable, calc_enable, tick;

  int n_cmp = 0;
  int n_err = 0;
  int m_x, m_y, m_hold;
  int x_chg_cyc, y_chg_cyc;

  viewport_ctrl #(
    .CDEPTH(CDEPTH), .ORG_W(ORG_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .STEP(STEP), .ACCEL_FRAMES(ACCEL),
    .DIV(DIV), .DISP_DELAY(DISP_DELAY), .CALC_DELAY(CALC_DELAY)
  ) dut (
    .CLK(CLK), .RST(RST), .vnotactive(vnotactive),
    .up(up), .down(down), .left(left), .right(right),
    .pix_in(pix_in), .red(red), .green(green), .blue(blue),
    .originX(originX), .originY(originY),
    .disp_enable(disp_enable), .calc_enable(calc_enable), .tick(tick)
  );

  always #5 CLK = ~CLK;

  // Reference movement rules on plain integers.
  function automatic int mdec(input int o, input int s, input int mx);
`ifdef VIEWPORT_WRAP_EN
    return (o - s + mx + 1) % (mx + 1);
`else
    return (o < s) ? 0 : o - s;
`endif
  endfunction

  function automatic int minc(input int o, input int s, input int mx);
`ifdef VIEWPORT_WRAP_EN
    return (o + s) % (mx + 1);
`else
    return (o + s > mx) ? mx : o + s;
`endif
  endfunction

  task automatic set_btns(input logic [3:0] b);
    {up, down, left, right} = b;
  endtask

  task automatic model_reset();
    m_x = X_INIT;
    m_y = Y_INIT;
    m_hold = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    vnotactive = 1'b0;
    set_btns(4'b1111);
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b1;
    model_reset();
  endtask

  // One video frame: short active period, then blanking with buttons b held.
  task automatic run_frame(input logic [3:0] b, input int blank);
    int ox, oy, s, xc, yc;
    logic [ORG_W-1:0] px, py;
    set_btns(b);
    vnotactive = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    s = (m_hold >= ACCEL) ? STEP * 4 : STEP;
    ox = m_x;
    oy = m_y;
    if (!b[3]) m_y = mdec(m_y, s, Y_MAX); else if (!b[2]) m_y = minc(m_y, s, Y_MAX);
    if (!b[1]) m_x = mdec(m_x, s, X_MAX); else if (!b[0]) m_x = minc(m_x, s, X_MAX);
    m_hold = (b != 4'b1111) ? ((m_hold < ACCEL) ? m_hold + 1 : ACCEL) : 0;
    px = originX; py = originY; xc = 0; yc = 0;
    x_chg_cyc = -1; y_chg_cyc = -1;
    vnotactive = 1'b1;
    for (int i = 0; i < blank; i++) begin
      @(posedge CLK); #1;
      if (originX !== px) begin xc++; x_chg_cyc = i; end
      if (originY !== py) begin yc++; y_chg_cyc = i; end
      px = originX; py = originY;
    end
    n_cmp++;
    if (originX !== ORG_W'(m_x)) begin
      n_err++; $display("FAIL frame_x btn=%b: got %0d expected %0d", b, originX, m_x);
    end
    n_cmp++;
    if (originY !== ORG_W'(m_y)) begin
      n_err++; $display("FAIL frame_y btn=%b: got %0d expected %0d", b, originY, m_y);
    end
    n_cmp++;
    if (xc != ((m_x != ox) ? 1 : 0) || yc != ((m_y != oy) ? 1 : 0)) begin
      n_err++; $display("FAIL frame_changes btn=%b: got x%0d/y%0d changes expected x%0d/y%0d",
                        b, xc, yc, (m_x != ox) ? 1 : 0, (m_y != oy) ? 1 : 0);
    end
    vnotactive = 1'b0;
    set_btns(4'b1111);
    @(posedge CLK); #1;
  endtask

  // Press b (with a release every 15 frames to keep the base step) until the model hits target.
  task automatic press_until(input logic [3:0] b, input bit on_x, input int target);
    int guard;
    guard = 0;
    while (((on_x ? m_x : m_y) != target) && guard < 500) begin
      run_frame((guard % 15 == 14) ? 4'b1111 : b, 3);
      guard++;
    end
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    n_cmp++;
    if ({red, green, blue} !== {PIXW{1'b1}}) begin
      n_err++; $display("FAIL reset_rgb: got %0h expected %0h", {red, green, blue}, {PIXW{1'b1}});
    end
    n_cmp++;
    if (originX !== ORG_W'(X_INIT)) begin
      n_err++; $display("FAIL reset_x: got %0d expected %0d", originX, X_INIT);
    end
    n_cmp++;
    if (originY !== ORG_W'(Y_INIT)) begin
      n_err++; $display("FAIL reset_y: got %0d expected %0d", originY, Y_INIT);
    end
    n_cmp++;
    if ({disp_enable, calc_enable, tick} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctl: got %b expected 000", {disp_enable, calc_enable, tick});
    end
    RST = 1'b1;
  endtask

  // Edge n counted from reset release; disp at DIV*(DISP_DELAY+1), calc at DIV*(CALC_DELAY+1).
  task automatic test_startup(input string tag);
    logic [PIXW-1:0] pix_prev, exp_rgb;
    int disp_edge, calc_edge;
    disp_edge = DIV * (DISP_DELAY + 1);
    calc_edge = DIV * (CALC_DELAY + 1);
    for (int n = 1; n <= calc_edge + 6; n++) begin
      pix_prev = PIXW'($urandom);
      pix_in = pix_prev;
      @(posedge CLK); #1;
      exp_rgb = (n > disp_edge) ? pix_prev : {PIXW{1'b1}};
      n_cmp++;
      if ({red, green, blue} !== exp_rgb) begin
        n_err++; $display("FAIL %s_rgb edge %0d: got %0h expected %0h", tag, n, {red, green, blue}, exp_rgb);
      end
      n_cmp++;
      if (tick !== ((n % DIV) == DIV - 1)) begin
        n_err++; $display("FAIL %s_tick edge %0d: got %b expected %b", tag, n, tick, (n % DIV) == DIV - 1);
      end
      n_cmp++;
      if (disp_enable !== (n >= disp_edge)) begin
        n_err++; $display("FAIL %s_disp edge %0d: got %b expected %b", tag, n, disp_enable, n >= disp_edge);
      end
      n_cmp++;
      if (calc_enable !== (n >= calc_edge)) begin
        n_err++; $display("FAIL %s_calc edge %0d: got %b expected %b", tag, n, calc_enable, n >= calc_edge);
      end
    end
  endtask

  task automatic test_reset_midop();
    run_frame(4'b0111, 3);
    run_frame(4'b1101, 3);
    n_cmp++;
    if (calc_enable !== 1'b1) begin
      n_err++; $display("FAIL midop_pre_calc: got %b expected 1", calc_enable);
    end
    set_btns(4'b0111);
    vnotactive = 1'b1;
    @(posedge CLK); #1;
    #2 RST = 1'b0;
    #1;
    n_cmp++;
    if ({red, green, blue} !== {PIXW{1'b1}}) begin
      n_err++; $display("FAIL midop_rgb: got %0h expected %0h", {red, green, blue}, {PIXW{1'b1}});
    end
    n_cmp++;
    if (originX !== ORG_W'(X_INIT) || originY !== ORG_W'(Y_INIT)) begin
      n_err++; $display("FAIL midop_origin: got %0d,%0d expected %0d,%0d", originX, originY, X_INIT, Y_INIT);
    end
    n_cmp++;
    if ({disp_enable, calc_enable, tick} !== 3'b000) begin
      n_err++; $display("FAIL midop_ctl: got %b expected 000", {disp_enable, calc_enable, tick});
    end
    vnotactive = 1'b0;
    set_btns(4'b1111);
    @(posedge CLK); #1;
    RST = 1'b1;
    model_reset();
    test_startup("restart");
  endtask

  task automatic test_up_hold();
    for (int f = 1; f <= 3; f++) begin
      run_frame(4'b0111, 100);
      n_cmp++;
      if (originY !== ORG_W'(Y_INIT - 2 * f)) begin
        n_err++; $display("FAIL up_hold frame %0d: got %0d expected %0d", f, originY, Y_INIT - 2 * f);
      end
    end
  endtask

  task automatic test_priority();
    run_frame(4'b1111, 3);
    run_frame(4'b0011, 4);
    run_frame(4'b1100, 4);
    run_frame(4'b0101, 6);
    n_cmp++;
    if (x_chg_cyc != y_chg_cyc || x_chg_cyc < 0) begin
      n_err++; $display("FAIL same_cycle: got x@%0d y@%0d expected equal and >=0", x_chg_cyc, y_chg_cyc);
    end
  endtask

  task automatic test_accel();
    do_reset();
    for (int f = 1; f <= 20; f++) begin
      run_frame(4'b1110, 3);
      if (f >= 16) begin
        n_cmp++;
        if (originX !== ORG_W'(332 + 8 * (f - 16))) begin
          n_err++; $display("FAIL accel frame %0d: got %0d expected %0d", f, originX, 332 + 8 * (f - 16));
        end
      end
    end
    run_frame(4'b1111, 3);
    run_frame(4'b1110, 3);
    n_cmp++;
    if (originX !== ORG_W'(366)) begin
      n_err++; $display("FAIL accel_release: got %0d expected 366", originX);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++)
      run_frame(4'($urandom), int'($urandom_range(3, 20)));
  endtask

  task automatic test_bounds();
    int exp_hi, exp_y;
    do_reset();
    press_until(4'b1110, 1'b1, X_MAX - 1);
    n_cmp++;
    if (originX !== ORG_W'(X_MAX - 1)) begin
      n_err++; $display("FAIL bound_reach_x: got %0d expected %0d", originX, X_MAX - 1);
    end
    run_frame(4'b1111, 3);
    run_frame(4'b1110, 3);
`ifdef VIEWPORT_WRAP_EN
    exp_hi = 0;
`else
    exp_hi = X_MAX;
`endif
    n_cmp++;
    if (originX !== ORG_W'(exp_hi)) begin
      n_err++; $display("FAIL bound_right: got %0d expected %0d", originX, exp_hi);
    end
`ifdef VIEWPORT_WRAP_EN
    run_frame(4'b1111, 3);
    run_frame(4'b1101, 3);
    n_cmp++;
    if (originX !== ORG_W'(X_MAX - 1)) begin
      n_err++; $display("FAIL bound_left_wrap: got %0d expected %0d", originX, X_MAX - 1);
    end
`else
    press_until(4'b1101, 1'b1, 1);
    run_frame(4'b1111, 3);
    run_frame(4'b1101, 3);
    n_cmp++;
    if (originX !== ORG_W'(0)) begin
      n_err++; $display("FAIL bound_left_clamp: got %0d expected 0", originX);
    end
`endif
    press_until(4'b0111, 1'b0, 0);
    run_frame(4'b1111, 3);
    run_frame(4'b0111, 3);
`ifdef VIEWPORT_WRAP_EN
    exp_y = Y_MAX - 1;
`else
    exp_y = 0;
`endif
    n_cmp++;
    if (originY !== ORG_W'(exp_y)) begin
      n_err++; $display("FAIL bound_up: got %0d expected %0d", originY, exp_y);
    end
  endtask

  initial begin
    test_reset();
    test_startup("startup");
    test_reset_midop();
    test_up_hold();
    test_priority();
    test_accel();
    test_random();
    test_bounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/viewport_ctrl.md
Name: viewport_ctrl

Overview:
- Parametrised successor to the chaos-map display front end.
- Registers the per-pixel colour from the map generator into the VGA RGB outputs.
- Sequences generator start-up with a prescaled tick.
- Pans a viewport origin from four active-low buttons, one step per vertical blanking interval, with hold-acceleration and bounded coordinates.
- Sits between the VGA timing generator, the push buttons and the logistic-map compute module.

Parameters:
- CDEPTH, 1, bits per colour channel.
- ORG_W, 10, width of originX/originY.
- X_MAX, 639, maximum originX value.
- Y_MAX, 479, maximum originY value.
- X_INIT, 300, reset value of originX.
- Y_INIT, 200, reset value of originY.
- STEP, 2, base pan step per frame.
- ACCEL_FRAMES, 16, consecutive held frames before the step becomes STEP*4.
- DIV, 4096, CLK cycles per start-up tick (at least 2).
- DISP_DELAY, 6, ticks before disp_enable asserts.
- CALC_DELAY, 15, ticks before calc_enable asserts (must be greater than DISP_DELAY).

Ports:
- CLK  in  1  system/pixel clock.
- RST  in  1  asynchronous active-low reset.
- vnotactive  in  1  high during vertical blanking.
- up, down, left, right  in  1 each  buttons, active-low.
- pix_in  in  3*CDEPTH  {red, green, blue} from the generator.
- red, green, blue  out  CDEPTH each  registered colour.
- originX, originY  out  ORG_W each  viewport origin.
- disp_enable  out  1  colour path enabled.
- calc_enable  out  1  generator run/reset release.
- tick  out  1  one-CLK pulse every DIV cycles.

Behaviour:
- Reset: clock and reset are fixed as one clock, CLK; reset RST is asynchronous, active-low. While RST is low:
  - red/green/blue are all ones (white).
  - originX=X_INIT, originY=Y_INIT.
  - disp_enable=0, calc_enable=0, tick=0.
  - Prescaler, start-up counter, hold counter and FSM are cleared.
  - Reset asserted mid-operation restarts the full start-up sequence.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick is high for the single cycle in which the count equals DIV-1.
- Start-up counter:
  - Increments on tick and saturates at CALC_DELAY.
  - disp_enable is set on the clock after the counter first equals DISP_DELAY. It is sticky.
  - calc_enable is set on the clock after the counter equals CALC_DELAY. It is sticky.
  - Both stay high until reset.
- Colour path:
  - When disp_enable=1, red/green/blue <= pix_in fields, giving 1-cycle latency. The MSB field is red.
  - When disp_enable=0, the outputs hold their value.
- Pan FSM, 3 states:
  - WAIT: go to ARM when vnotactive=1.
  - ARM: lasts one cycle. Apply the vertical and horizontal moves below. If any button is low, go to DONE. Otherwise, if vnotactive=0, go to WAIT; else stay in ARM.
  - DONE: go to WAIT when vnotactive=0.
  - Net effect: at most one move per blanking interval.
- Direction priority:
  - up beats down; up decrements Y.
  - left beats right; left decrements X.
  - X and Y move independently in the same cycle.
- Acceleration:
  - hold_cnt (saturating at ACCEL_FRAMES) increments on each ARM move cycle where any button is low.
  - hold_cnt clears on an ARM cycle with no button pressed.
  - The step is STEP while hold_cnt < ACCEL_FRAMES, else STEP*4.
  - Arithmetic is computed in ORG_W+1 bits so no intermediate overflow occurs.
- Bounds (default build, clamp):
  - Decrement: result = 0 if origin < step, else origin - step.
  - Increment: result = MAX if origin + step > MAX, else origin + step.
- Buttons and vnotactive are used as-is. The synchronisers are upstream.

Optional Feature:
- Macro: VIEWPORT_WRAP_EN.
- Defined: coordinates wrap modulo (MAX+1).
  - Decrement below 0 gives MAX+1-(step-origin).
  - Increment above MAX gives origin+step-(MAX+1).
- Undefined: clamp behaviour as specified under Behaviour.

Test Plan:
- Reset release, DIV=4, DISP_DELAY=6, CALC_DELAY=15 -> disp_enable rises 1 clock after the 7th tick (cycle 28), calc_enable 1 clock after the 16th tick (cycle 64); red/green/blue=1 until then, then follow pix_in with 1-cycle latency.
- up held low for 3 blanking intervals from Y=200 -> originY=198, 196, 194; exactly one change per interval even when vnotactive stays high for 100 cycles.
- up and down both low -> Y decreases; left and right both low -> X decreases; a simultaneous up+left press changes both in the same cycle.
- right held for 20 frames from X=300, ACCEL_FRAMES=16, STEP=2 -> X=332 after 16 frames, then +8 per frame: 340, 348, 356, 364; releasing for one frame restores step 2.
- Clamp build: X=1 with left -> 0; X=638 with right -> 639. VIEWPORT_WRAP_EN build: X=1 with left -> 639; X=638 with right -> 0.
- Assert RST in the middle of a pan and after calc_enable=1 -> all outputs return to reset values immediately; the start-up sequence repeats with identical timing.
